// File: rtl/mdio_pkg.sv
// Shared constants, state encoding and field boundaries for the clause-22 MDIO receptor.
package mdio_pkg;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST_CL22  = 2'b01;

  // Field boundaries expressed as MDC rise counts within a frame.
  localparam int RISE_HDR_END   = 14;
  localparam int RISE_TA_END    = 16;
  localparam int RISE_FRAME_END = 32;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WR_TA,
    WR_DATA,
    RD_TA,
    RD_DATA,
    SKIP
  } state_t;

endpackage

// File: rtl/mdio_receptor_if.sv
// MDIO serial pins plus the local register-side strobes, grouped for the receptor.
interface mdio_receptor_if;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_oe;
  logic        mdio_in;
  logic        mdio_in_en;
  logic [4:0]  reg_addr;
  logic [15:0] wr_data;
  logic        wr_stb;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        frame_err;

  modport master (
    output mdc, mdio_out, mdio_oe, rd_data,
    input  mdio_in, mdio_in_en, reg_addr, wr_data, wr_stb, rd_req, frame_err
  );

  modport slave (
    input  mdc, mdio_out, mdio_oe, rd_data,
    output mdio_in, mdio_in_en, reg_addr, wr_data, wr_stb, rd_req, frame_err
  );
endinterface

// File: rtl/mdc_edge_det.sv
// MDC rise/fall detector; one register, edges valid combinationally in the detect cycle.
// No backpressure; MDC shares clk so no synchroniser is needed.
module mdc_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic mdc,
  output logic rise,
  output logic fall
);
  logic mdc_q;

  // Preset high so an MDC already high when reset drops is not taken as a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mdc_q <= 1'b1;
    else       mdc_q <= mdc;
  end

  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;
endmodule

// File: rtl/mdio_receptor.sv
// Clause-22 MDIO frame decoder: write strobe/read request one clk after the deciding rise,
// read bits driven one clk after each MDC fall. No backpressure. Optional MDIO_ST_CHECK_EN.
module mdio_receptor
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'h15
) (
  input logic              clk,
  input logic              reset,
  mdio_receptor_if.slave   bus
);
  localparam logic [4:0] CNT_HDR_LAST   = 5'(RISE_HDR_END - 1);
  localparam logic [4:0] CNT_TA_LAST    = 5'(RISE_TA_END - 1);
  localparam logic [4:0] CNT_TA_END     = 5'(RISE_TA_END);
  localparam logic [4:0] CNT_FRAME_LAST = 5'(RISE_FRAME_END - 1);
  // bit_cnt wraps to zero on rise 32; that value marks the final fall of a read.
  localparam logic [4:0] CNT_FRAME_WRAP = 5'(RISE_FRAME_END);

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [10:0] hdr_sr;
  logic [14:0] data_sr;
  logic        mdio_in_q;
  logic        mdio_in_en_q;
  logic [4:0]  reg_addr_q;
  logic [15:0] wr_data_q;
  logic        wr_stb_q;
  logic        rd_req_q;
  logic        frame_err_q;
  logic        mdc_rise;
  logic        mdc_fall;
  logic [1:0]  hdr_op;
  logic [4:0]  hdr_phyad;
  logic [4:0]  hdr_regad;

  mdc_edge_det u_edge (
    .clk   (clk),
    .reset (reset),
    .mdc   (bus.mdc),
    .rise  (mdc_rise),
    .fall  (mdc_fall)
  );

  // hdr_sr keeps rises 3..13; the rise-14 bit is taken straight off the wire at decode.
  assign hdr_op    = hdr_sr[10:9];
  assign hdr_phyad = hdr_sr[8:4];
  assign hdr_regad = {hdr_sr[3:0], bus.mdio_out};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      hdr_sr       <= '0;
      data_sr      <= '0;
      mdio_in_q    <= 1'b0;
      mdio_in_en_q <= 1'b0;
      reg_addr_q   <= '0;
      wr_data_q    <= '0;
      wr_stb_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_stb_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (mdc_rise && bus.mdio_oe) begin
            state   <= HDR;
            bit_cnt <= 5'd1;
            hdr_sr  <= {hdr_sr[9:0], bus.mdio_out};
          end
        end
        HDR: begin
          if (mdc_rise) begin
            if (!bus.mdio_oe) begin
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end
`ifdef MDIO_ST_CHECK_EN
            else if (bit_cnt == 5'd1 && {hdr_sr[0], bus.mdio_out} != ST_CL22) begin
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end
`endif
            else begin
              hdr_sr  <= {hdr_sr[9:0], bus.mdio_out};
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == CNT_HDR_LAST) begin
                if (hdr_phyad != PHY_ADDR) begin
                  state <= SKIP;
                end else begin
                  reg_addr_q <= hdr_regad;
                  if (hdr_op == OP_WRITE) begin
                    state <= WR_TA;
                  end else if (hdr_op == OP_READ) begin
                    rd_req_q <= 1'b1;
                    state    <= RD_TA;
                  end else begin
                    frame_err_q <= 1'b1;
                    state       <= IDLE;
                  end
                end
              end
            end
          end
        end
        WR_TA: begin
          if (mdc_rise) begin
            if (!bus.mdio_oe) begin
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == CNT_TA_LAST) state <= WR_DATA;
            end
          end
        end
        WR_DATA: begin
          if (mdc_rise) begin
            if (!bus.mdio_oe) begin
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end else if (bit_cnt == CNT_FRAME_LAST) begin
              wr_data_q <= {data_sr, bus.mdio_out};
              wr_stb_q  <= 1'b1;
              state     <= IDLE;
            end else begin
              data_sr <= {data_sr[13:0], bus.mdio_out};
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        RD_TA: begin
          if (mdc_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
          end else if (mdc_fall) begin
            if (bit_cnt == CNT_TA_LAST) begin
              mdio_in_en_q <= 1'b1;
              mdio_in_q    <= 1'b0;
            end else if (bit_cnt == CNT_TA_END) begin
              data_sr   <= bus.rd_data[14:0];
              mdio_in_q <= bus.rd_data[15];
              state     <= RD_DATA;
            end
          end
        end
        RD_DATA: begin
          if (mdc_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
          end else if (mdc_fall) begin
            if (bit_cnt == CNT_FRAME_WRAP) begin
              mdio_in_en_q <= 1'b0;
              mdio_in_q    <= 1'b0;
              state        <= IDLE;
            end else begin
              mdio_in_q <= data_sr[14];
              data_sr   <= {data_sr[13:0], 1'b0};
            end
          end
        end
        SKIP: begin
          if (mdc_rise) begin
            if (bit_cnt == CNT_FRAME_LAST) state <= IDLE;
            else                          bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mdio_in    = mdio_in_q;
  assign bus.mdio_in_en = mdio_in_en_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_stb     = wr_stb_q;
  assign bus.rd_req     = rd_req_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_mdio_receptor.sv
// Randomised MDIO controller plus frame-level reference model and event scoreboard for mdio_receptor.
module tb_mdio_receptor;
  localparam logic [4:0] PHY = 5'h15;
  localparam int EV_WR  = 0;
  localparam int EV_RD  = 1;
  localparam int EV_ERR = 2;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [15:0] data;
    int          due;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          stray = 0;
  bit          drive_ok = 1'b0;
  ev_t         exp_q[$];
  logic [15:0] regs[32];
  ev_t         mon_e;
  int          mon_kind;

  mdio_receptor_if bus();

  mdio_receptor #(.PHY_ADDR(PHY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                     input logic [4:0] phy, input logic [4:0] rg,
                                     input logic [15:0] d);
    return {st, op, phy, rg, 2'b10, d};
  endfunction

  // How long a well-behaved controller keeps driving: whole write frames, header only otherwise.
  function automatic int ctrl_oe_len(input logic [31:0] f);
`ifdef MDIO_ST_CHECK_EN
    if (f[31:30] != 2'b01) return 2;
`endif
    if (f[29:28] == 2'b01) return 32;
    return 14;
  endfunction

  function automatic void push(input int kind, input logic [4:0] a, input logic [15:0] d,
                               input int s, input int r);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.due  = s + 4 * r - 1;
    exp_q.push_back(e);
  endfunction

  // Frame-level model: returns 1 when the frame is a read the receptor must answer.
  function automatic bit model(input logic [31:0] f, input int oe_len, input int s);
    logic [1:0]  st = f[31:30];
    logic [1:0]  op = f[29:28];
    logic [4:0]  phy = f[27:23];
    logic [4:0]  rg = f[22:18];
    logic [15:0] d = f[15:0];
`ifdef MDIO_ST_CHECK_EN
    if (oe_len >= 2 && st != 2'b01) begin
      push(EV_ERR, 5'h0, 16'h0, s, 2);
      return 1'b0;
    end
`else
    if (st == 2'b11) st = 2'b11;
`endif
    if (oe_len < 14) begin
      push(EV_ERR, 5'h0, 16'h0, s, oe_len + 1);
      return 1'b0;
    end
    if (phy != PHY) return 1'b0;
    if (op == 2'b10) begin
      push(EV_RD, rg, 16'h0, s, 14);
      return 1'b1;
    end
    if (op == 2'b01) begin
      if (oe_len < 32) begin
        push(EV_ERR, 5'h0, 16'h0, s, oe_len + 1);
      end else begin
        push(EV_WR, rg, d, s, 32);
        regs[rg] = d;
      end
      return 1'b0;
    end
    push(EV_ERR, 5'h0, 16'h0, s, 14);
    return 1'b0;
  endfunction

  // Controller: MDC = clk/4, bits changed in the low phase, read bits sampled just before each rise.
  task automatic send_frame(input logic [31:0] f, input int oe_len, input logic [15:0] rdval,
                            input int rst_at);
    int          s;
    bit          rd_here;
    logic [15:0] got;
    got = '0;
    s = cyc;
    rd_here = model(f, oe_len, s);
    bus.rd_data = rdval;
    drive_ok = rd_here;
    for (int i = 1; i <= 32; i++) begin
      bus.mdc = 1'b0;
      bus.mdio_out = f[32-i];
      bus.mdio_oe = (i <= oe_len);
      @(negedge clk);
      @(negedge clk);
      if (rd_here && i == 16) check("ta2_drive", 32'({bus.mdio_in_en, bus.mdio_in}), 32'h2);
      if (rd_here && i >= 17) got[32-i] = bus.mdio_in;
      bus.mdc = 1'b1;
      if (i == rst_at) begin
        reset = 1'b1;
        #1;
        check("reset_release", 32'({bus.mdio_in_en, bus.mdio_in}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive_ok = 1'b0;
        bus.mdc = 1'b0;
        bus.mdio_oe = 1'b0;
        return;
      end
      @(negedge clk);
      @(negedge clk);
    end
    if (rd_here) begin
      check("rd_word", 32'(got), 32'(rdval));
      bus.mdc = 1'b0;
      bus.mdio_oe = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rd_bus_free", 32'({bus.mdio_in_en, bus.mdio_in}), 32'h0);
      drive_ok = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mdio_in_en && !drive_ok) stray++;
      if (bus.wr_stb || bus.rd_req || bus.frame_err) begin
        mon_kind = bus.wr_stb ? EV_WR : (bus.rd_req ? EV_RD : EV_ERR);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind %0d at cyc %0d, none expected", mon_kind, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_kind != mon_e.kind || cyc != mon_e.due ||
              (mon_e.kind != EV_ERR && bus.reg_addr !== mon_e.addr) ||
              (mon_e.kind == EV_WR && bus.wr_data !== mon_e.data)) begin
            errors++;
            $display("FAIL event got kind %0d cyc %0d addr %h data %h, want kind %0d cyc %0d addr %h data %h",
                     mon_kind, cyc, bus.reg_addr, bus.wr_data,
                     mon_e.kind, mon_e.due, mon_e.addr, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] f;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] d;
    int          ol;
    bus.mdc = 1'b0;
    bus.mdio_out = 1'b0;
    bus.mdio_oe = 1'b0;
    bus.rd_data = 16'h0;
    for (int i = 0; i < 32; i++) regs[i] = 16'h0;

    @(negedge clk);
    @(negedge clk);
    check("rst_mdio_in", 32'(bus.mdio_in), 32'h0);
    check("rst_mdio_in_en", 32'(bus.mdio_in_en), 32'h0);
    check("rst_reg_addr", 32'(bus.reg_addr), 32'h0);
    check("rst_wr_data", 32'(bus.wr_data), 32'h0);
    check("rst_wr_stb", 32'(bus.wr_stb), 32'h0);
    check("rst_rd_req", 32'(bus.rd_req), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    f = 32'h9AB87652;
    send_frame(f, ctrl_oe_len(f), 16'h0, 0);
    f = 32'h2AB80000;
    send_frame(f, ctrl_oe_len(f), 16'hA5C3, 0);

    f = mk(2'b01, 2'b01, 5'h03, 5'h07, 16'h1234);
    send_frame(f, ctrl_oe_len(f), 16'h0, 0);
    f = mk(2'b01, 2'b01, PHY, 5'h07, 16'hBEEF);
    send_frame(f, ctrl_oe_len(f), 16'h0, 0);

    f = mk(2'b01, 2'b01, PHY, 5'h09, 16'h5555);
    send_frame(f, 19, 16'h0, 0);
    f = mk(2'b01, 2'b10, PHY, 5'h07, 16'h0);
    send_frame(f, ctrl_oe_len(f), regs[7], 0);

    f = mk(2'b01, 2'b10, PHY, 5'h01, 16'h0);
    send_frame(f, ctrl_oe_len(f), 16'hFFFF, 24);
    f = mk(2'b01, 2'b01, PHY, 5'h02, 16'hCAFE);
    send_frame(f, ctrl_oe_len(f), 16'h0, 0);

    f = mk(2'b01, 2'b11, PHY, 5'h03, 16'h0);
    send_frame(f, ctrl_oe_len(f), 16'h0, 0);
    f = mk(2'b10, 2'b01, PHY, 5'h04, 16'h1111);
    send_frame(f, ctrl_oe_len(f), 16'h0, 0);

    for (int n = 0; n < 40; n++) begin
      st  = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b01;
      op  = 2'($urandom);
      phy = ($urandom_range(3) == 0) ? 5'($urandom) : PHY;
      rg  = 5'($urandom);
      d   = 16'($urandom);
      f   = mk(st, op, phy, rg, d);
      ol  = ctrl_oe_len(f);
      if (ol == 32 && $urandom_range(4) == 0) ol = int'($urandom_range(31, 2));
      send_frame(f, ol, regs[rg], 0);
    end

    bus.mdc = 1'b0;
    bus.mdio_oe = 1'b0;
    repeat (20) @(negedge clk);
    check("events_drained", 32'(exp_q.size()), 32'h0);
    check("stray_drive", 32'(stray), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdio_receptor.md
# mdio_receptor

Management-side MDIO receiver that sits directly downstream of the MDIO controller and decodes each 32-bit clause-22 frame it shifts out on `mdc`/`mdio_out`. Write frames become a one-cycle register-write strobe. Read frames fetch a 16-bit value from the local register interface and serialise it back to the controller on `mdio_in`. MDC is generated from the same `clk`, so the block needs no synchroniser: it edge-detects MDC with a single register.

## Interface
- `PHY_ADDR`, default 5'h15: PHY address this receptor answers to.
- `clk` input 1: system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high; all state and outputs are cleared while it is high.
- `mdc` input 1: management clock from the controller; high and low phases are each at least 2 `clk` cycles.
- `mdio_out` input 1: serial data from the controller.
- `mdio_oe` input 1: controller drive enable; 1 means the controller is driving `mdio_out`.
- `mdio_in` output 1: serial read data returned to the controller.
- `mdio_in_en` output 1: receptor drive enable for `mdio_in`.
- `reg_addr` output 5: REGAD of the current frame.
- `wr_data` output 16: captured write data.
- `wr_stb` output 1: one-cycle write strobe.
- `rd_req` output 1: one-cycle read request.
- `rd_data` input 16: read value; must be valid from `rd_req` + 1 `clk` until the fall after rise 16.
- `frame_err` output 1: one-cycle pulse on an aborted frame or an illegal opcode.

## Operation
- Edge detection:
  - rise = `mdc & ~mdc_q`; fall = `~mdc & mdc_q`.
  - `mdio_out` is sampled combinationally in the rise cycle.
- Frame bit numbering, by MDC rise count within the frame:
  - ST on rises 1–2, OP on 3–4, PHYAD on 5–9, REGAD on 10–14 (all MSB first).
  - TA on rises 15–16.
  - DATA on rises 17–32 (bit 15 first).
- States:
  - IDLE: the first rise with `mdio_oe`=1 is taken as rise 1 (no preamble). Go to HDR.
  - HDR: shift in rises 1–14 using a 5-bit `bit_cnt`. After rise 14, decode:
    - PHYAD ≠ `PHY_ADDR`: go to SKIP silently.
    - OP=01: go to WR_TA.
    - OP=10: pulse `rd_req` and go to RD_TA.
    - OP=00 or 11: pulse `frame_err` and go to IDLE.
  - WR_TA: ignore the values on rises 15–16, then go to WR_DATA.
  - WR_DATA: shift rises 17–32 into `wr_data`. After rise 32, pulse `wr_stb` and go to IDLE.
  - RD_TA: at the fall after rise 15, set `mdio_in_en`=1 and `mdio_in`=0. At the fall after rise 16, load `rd_data` into the shift register and drive bit 15. Go to RD_DATA.
  - RD_DATA: at each fall after rises 17–31, drive the next bit. At the fall after rise 32, clear `mdio_in_en` and `mdio_in`, then go to IDLE.
  - SKIP: count to rise 32 without driving, then go to IDLE.
- Abort: if `mdio_oe`=0 on any rise in HDR, WR_TA or WR_DATA, pulse `frame_err`, go to IDLE, and issue no `wr_stb`.
- `reg_addr` updates only at decode and holds until the next decode.
- Reset mid-frame: everything returns to IDLE immediately and the bus is released.

## Timing
- Reset values: `mdio_in`=0, `mdio_in_en`=0, `reg_addr`=0, `wr_data`=0, `wr_stb`=0, `rd_req`=0, `frame_err`=0.
- `rd_req` is asserted on the `clk` cycle after the rise-14 cycle.
- `wr_stb` is asserted on the `clk` cycle after the rise-32 cycle; `wr_data` and `reg_addr` are stable during the strobe.
- `mdio_in` changes exactly one `clk` after the fall-detect cycle. This makes it stable at least 1 `clk` before the next MDC rise, which the controller samples.
- A rise and a `reset` deassertion in the same cycle: the rise is ignored.
- Back-to-back frames: IDLE accepts a rise-1 on the very next rise after rise 32.

## Configuration
- `MDIO_ST_CHECK_EN`:
  - Defined: after rise 2, ST ≠ 01 pulses `frame_err` and returns the block to IDLE.
  - Undefined: the ST bits are ignored.

## Structure
- Package `mdio_pkg` holds:
  - the OP_WRITE=2'b01 and OP_READ=2'b10 constants;
  - the state enum (IDLE, HDR, WR_TA, WR_DATA, RD_TA, RD_DATA, SKIP);
  - the field-boundary rise counts (14, 16, 32).
- Sub-module `mdc_edge_det` contains the `mdc_q` register and the rise/fall outputs.

## Test plan
- Write frame 32'h9AB87652, MDC=`clk`/4 -> `wr_stb` pulses once with `reg_addr`=5'h0E and `wr_data`=16'h7652; `mdio_in_en` stays 0.
- Read frame 32'h2AB8xxxx with `rd_data`=16'hA5C3 -> `rd_req` pulses after rise 14; `mdio_in` is 0 during TA2, then bits 1010010111000011 MSB first; released after rise 32.
- Write frame with PHYAD 5'h03 -> no `wr_stb`, no `frame_err`, no drive; a following valid write is accepted.
- `mdio_oe` dropped at rise 20 of a write -> one `frame_err` pulse and no `wr_stb`; the next frame decodes correctly.
- `reset` asserted at rise 24 of a read -> `mdio_in_en`=0 immediately and the block is in IDLE.
- Frame with OP=11 -> `frame_err` pulse after rise 14.
- With `MDIO_ST_CHECK_EN` defined, ST=10 -> `frame_err` after rise 2.
